// File: rtl/aq_axi_sdma_master_p_if.sv
// AXI4 master bundle for the sdma master: AW/W/B/AR/R channels plus constant sidebands.
interface aq_axi_sdma_master_p_if #(
  parameter int unsigned DATA_W = 64
);
  localparam int unsigned BYTES = DATA_W / 8;

  logic [31:0]       AWADDR;
  logic [7:0]        AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic              AWVALID;
  logic              AWREADY;
  logic              AWID;
  logic              AWLOCK;
  logic [3:0]        AWCACHE;
  logic [2:0]        AWPROT;
  logic [3:0]        AWQOS;
  logic              AWUSER;

  logic [DATA_W-1:0] WDATA;
  logic [BYTES-1:0]  WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;

  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;

  logic [31:0]       ARADDR;
  logic [7:0]        ARLEN;
  logic [2:0]        ARSIZE;
  logic [1:0]        ARBURST;
  logic              ARVALID;
  logic              ARREADY;
  logic              ARID;
  logic              ARLOCK;
  logic [3:0]        ARCACHE;
  logic [2:0]        ARPROT;
  logic [3:0]        ARQOS;
  logic              ARUSER;

  logic [DATA_W-1:0] RDATA;
  logic [1:0]        RRESP;
  logic              RLAST;
  logic              RVALID;
  logic              RREADY;

  modport master (
    output AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, AWID, AWLOCK, AWCACHE, AWPROT, AWQOS,
           AWUSER,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY,
    output ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, ARID, ARLOCK, ARCACHE, ARPROT, ARQOS,
           ARUSER,
    input  ARREADY,
    input  RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID, AWID, AWLOCK, AWCACHE, AWPROT, AWQOS,
           AWUSER,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID, ARID, ARLOCK, ARCACHE, ARPROT, ARQOS,
           ARUSER,
    output ARREADY,
    output RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/aq_axi_sdma_master_p.sv
// Single-outstanding-burst AXI4 DMA master: FIFO->memory write channel and memory->FIFO read
// channel, each splitting jobs into bursts that never cross a 4KB boundary.
module aq_axi_sdma_master_p #(
  parameter int unsigned DATA_W    = 64,
  parameter int unsigned MAX_BURST = 256,
  parameter int unsigned LVL_W     = 10
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  aq_axi_sdma_master_p_if.master m_axi,
  input  logic                  MASTER_RST,
  input  logic                  WR_START,
  input  logic [31:0]           WR_ADRS,
  input  logic [31:0]           WR_LEN,
  output logic                  WR_READY,
  output logic                  WR_INT,
  output logic [1:0]            WR_STATUS,
  output logic                  WR_FIFO_RE,
  input  logic [DATA_W-1:0]     WR_FIFO_DATA,
  input  logic [LVL_W-1:0]      WR_FIFO_LEVEL,
  input  logic                  RD_START,
  input  logic [31:0]           RD_ADRS,
  input  logic [31:0]           RD_LEN,
  output logic                  RD_READY,
  output logic                  RD_INT,
  output logic [1:0]            RD_STATUS,
  output logic                  RD_FIFO_WE,
  output logic [DATA_W-1:0]     RD_FIFO_DATA,
  input  logic [LVL_W-1:0]      RD_FIFO_FREE
);
  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned SH    = $clog2(BYTES);

  // min(MAX_BURST, remaining beats, beats left before the next 4KB boundary)
  function automatic logic [8:0] calc_beats(input logic [31:0] adr, input logic [31:0] rem);
    logic [31:0] n;
    logic [31:0] bnd;
    n   = rem >> SH;
    bnd = (32'd4096 - {20'd0, adr[11:0]}) >> SH;
    if (bnd < n) n = bnd;
    if (32'(MAX_BURST) < n) n = 32'(MAX_BURST);
    return n[8:0];
  endfunction

  typedef enum logic [2:0] {WIdle, WCalc, WGate, WAddr, WData, WResp} wst_e;
  typedef enum logic [2:0] {RIdle, RCalc, RGate, RAddr, RData} rst_e;

  wst_e        w_st_q;
  logic [31:0] w_adr_q, w_rem_q, w_bytes;
  logic [8:0]  w_beats_q, w_cnt_q, w_beats_c;
  logic        w_abort_q, wr_int_q, awvalid_q, wvalid_q, wlast_q, bready_q;
  logic [1:0]  wr_status_q;
  logic [31:0] awaddr_q;
  logic [7:0]  awlen_q;

  rst_e        r_st_q;
  logic [31:0] r_adr_q, r_rem_q, r_bytes;
  logic [8:0]  r_beats_q, r_beats_c;
  logic        r_abort_q, arvalid_q, rready_q;
  logic [1:0]  rd_status_q;
  logic [31:0] araddr_q;
  logic [7:0]  arlen_q;

  assign w_beats_c = calc_beats(w_adr_q, w_rem_q);
  assign r_beats_c = calc_beats(r_adr_q, r_rem_q);
  assign w_bytes   = {23'd0, w_beats_q} << SH;
  assign r_bytes   = {23'd0, r_beats_q} << SH;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_st_q      <= WIdle;
      w_adr_q     <= '0;
      w_rem_q     <= '0;
      w_beats_q   <= '0;
      w_cnt_q     <= '0;
      w_abort_q   <= 1'b0;
      wr_int_q    <= 1'b0;
      wr_status_q <= '0;
      awaddr_q    <= '0;
      awlen_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      wlast_q     <= 1'b0;
      bready_q    <= 1'b0;
    end else begin
      wr_int_q <= 1'b0;
      if (MASTER_RST && w_st_q != WIdle) w_abort_q <= 1'b1;
      case (w_st_q)
        WIdle: begin
          if (WR_START && !MASTER_RST) begin
            w_adr_q     <= WR_ADRS;
            w_rem_q     <= WR_LEN;
            wr_status_q <= '0;
            if (WR_LEN == 32'd0) wr_int_q <= 1'b1;
            else                 w_st_q   <= WCalc;
          end
        end
        WCalc: begin
          if (w_abort_q || MASTER_RST) begin
            w_st_q    <= WIdle;
            w_abort_q <= 1'b0;
          end else begin
            w_beats_q <= w_beats_c;
            awaddr_q  <= w_adr_q;
            awlen_q   <= 8'(w_beats_c - 9'd1);
            w_st_q    <= WGate;
          end
        end
        WGate: begin
          if (w_abort_q || MASTER_RST) begin
            w_st_q    <= WIdle;
            w_abort_q <= 1'b0;
          end else if (32'(WR_FIFO_LEVEL) >= 32'(w_beats_q)) begin
            awvalid_q <= 1'b1;
            w_st_q    <= WAddr;
          end
        end
        WAddr: begin
          if (m_axi.AWREADY) begin
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b1;
            wlast_q   <= (w_beats_q == 9'd1);
            w_cnt_q   <= 9'd1;
            w_st_q    <= WData;
          end
        end
        WData: begin
          if (m_axi.WREADY) begin
            if (wlast_q) begin
              wvalid_q <= 1'b0;
              wlast_q  <= 1'b0;
              bready_q <= 1'b1;
              w_st_q   <= WResp;
            end else begin
              w_cnt_q <= w_cnt_q + 9'd1;
              wlast_q <= (w_cnt_q + 9'd1 == w_beats_q);
            end
          end
        end
        WResp: begin
          if (m_axi.BVALID) begin
            bready_q    <= 1'b0;
            wr_status_q <= wr_status_q | m_axi.BRESP;
            w_adr_q     <= w_adr_q + w_bytes;
            w_rem_q     <= w_rem_q - w_bytes;
            if (w_abort_q || MASTER_RST) begin
              w_st_q    <= WIdle;
              w_abort_q <= 1'b0;
            end else if (w_rem_q == w_bytes) begin
              wr_int_q <= 1'b1;
              w_st_q   <= WIdle;
            end else begin
              w_st_q <= WCalc;
            end
          end
        end
        default: w_st_q <= WIdle;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_st_q      <= RIdle;
      r_adr_q     <= '0;
      r_rem_q     <= '0;
      r_beats_q   <= '0;
      r_abort_q   <= 1'b0;
      rd_status_q <= '0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      arvalid_q   <= 1'b0;
      rready_q    <= 1'b0;
    end else begin
      if (MASTER_RST && r_st_q != RIdle) r_abort_q <= 1'b1;
      case (r_st_q)
        RIdle: begin
          if (RD_START && !MASTER_RST) begin
            r_adr_q     <= RD_ADRS;
            r_rem_q     <= RD_LEN;
            rd_status_q <= '0;
            if (RD_LEN != 32'd0) r_st_q <= RCalc;
          end
        end
        RCalc: begin
          if (r_abort_q || MASTER_RST) begin
            r_st_q    <= RIdle;
            r_abort_q <= 1'b0;
          end else begin
            r_beats_q <= r_beats_c;
            araddr_q  <= r_adr_q;
            arlen_q   <= 8'(r_beats_c - 9'd1);
            r_st_q    <= RGate;
          end
        end
        RGate: begin
          if (r_abort_q || MASTER_RST) begin
            r_st_q    <= RIdle;
            r_abort_q <= 1'b0;
          end else if (32'(RD_FIFO_FREE) >= 32'(r_beats_q)) begin
            arvalid_q <= 1'b1;
            r_st_q    <= RAddr;
          end
        end
        RAddr: begin
          if (m_axi.ARREADY) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            r_st_q    <= RData;
          end
        end
        RData: begin
          if (m_axi.RVALID) begin
            rd_status_q <= rd_status_q | m_axi.RRESP;
            // RLAST closes the burst regardless of how many beats were counted
            if (m_axi.RLAST) begin
              rready_q <= 1'b0;
              r_adr_q  <= r_adr_q + r_bytes;
              r_rem_q  <= r_rem_q - r_bytes;
              if (r_abort_q || MASTER_RST) begin
                r_st_q    <= RIdle;
                r_abort_q <= 1'b0;
              end else if (r_rem_q == r_bytes) begin
                r_st_q <= RIdle;
              end else begin
                r_st_q <= RCalc;
              end
            end
          end
        end
        default: r_st_q <= RIdle;
      endcase
    end
  end

  assign m_axi.AWADDR  = awaddr_q;
  assign m_axi.AWLEN   = awlen_q;
  assign m_axi.AWSIZE  = 3'(SH);
  assign m_axi.AWBURST = 2'b01;
  assign m_axi.AWVALID = awvalid_q;
  assign m_axi.AWID    = 1'b0;
  assign m_axi.AWLOCK  = 1'b0;
  assign m_axi.AWCACHE = 4'b0011;
  assign m_axi.AWPROT  = 3'b000;
  assign m_axi.AWQOS   = 4'b0000;
  assign m_axi.AWUSER  = 1'b1;
  assign m_axi.WDATA   = WR_FIFO_DATA;
  assign m_axi.WSTRB   = '1;
  assign m_axi.WLAST   = wlast_q;
  assign m_axi.WVALID  = wvalid_q;
  assign m_axi.BREADY  = bready_q;

  assign m_axi.ARADDR  = araddr_q;
  assign m_axi.ARLEN   = arlen_q;
  assign m_axi.ARSIZE  = 3'(SH);
  assign m_axi.ARBURST = 2'b01;
  assign m_axi.ARVALID = arvalid_q;
  assign m_axi.ARID    = 1'b0;
  assign m_axi.ARLOCK  = 1'b0;
  assign m_axi.ARCACHE = 4'b0011;
  assign m_axi.ARPROT  = 3'b000;
  assign m_axi.ARQOS   = 4'b0000;
  assign m_axi.ARUSER  = 1'b1;
  assign m_axi.RREADY  = rready_q;

  assign WR_READY     = (w_st_q == WIdle);
  assign WR_INT       = wr_int_q;
  assign WR_STATUS    = wr_status_q;
  assign WR_FIFO_RE   = wvalid_q & m_axi.WREADY;

  assign RD_READY     = (r_st_q == RIdle);
  assign RD_STATUS    = rd_status_q;
  // Beats of an aborted burst are drained from the bus but never reach the FIFO
  assign RD_FIFO_WE   = rready_q & m_axi.RVALID & ~r_abort_q;
  assign RD_FIFO_DATA = m_axi.RDATA;
  assign RD_INT       = (r_st_q == RData) & m_axi.RVALID & m_axi.RLAST & ~r_abort_q &
                        ~MASTER_RST & (r_rem_q == r_bytes);
endmodule

// File: tb/tb_aq_axi_sdma_master_p.sv
// Directed bench for aq_axi_sdma_master_p: a small AXI slave model plus monitors, with checks
// on burst splitting, FIFO gating, sticky status, zero-length jobs and abort.
module tb_aq_axi_sdma_master_p;
  localparam int unsigned DATA_W = 64;

  logic ACLK;
  logic ARESETN;
  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  aq_axi_sdma_master_p_if #(.DATA_W(DATA_W)) axi ();

  logic              MASTER_RST, WR_START, RD_START;
  logic [31:0]       WR_ADRS, WR_LEN, RD_ADRS, RD_LEN;
  logic              WR_READY, WR_INT, RD_READY, RD_INT, WR_FIFO_RE, RD_FIFO_WE;
  logic [1:0]        WR_STATUS, RD_STATUS;
  logic [DATA_W-1:0] WR_FIFO_DATA, RD_FIFO_DATA;
  logic [9:0]        WR_FIFO_LEVEL, RD_FIFO_FREE;

  aq_axi_sdma_master_p #(.DATA_W(DATA_W), .MAX_BURST(256), .LVL_W(10)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .m_axi(axi), .MASTER_RST(MASTER_RST),
    .WR_START(WR_START), .WR_ADRS(WR_ADRS), .WR_LEN(WR_LEN), .WR_READY(WR_READY),
    .WR_INT(WR_INT), .WR_STATUS(WR_STATUS), .WR_FIFO_RE(WR_FIFO_RE),
    .WR_FIFO_DATA(WR_FIFO_DATA), .WR_FIFO_LEVEL(WR_FIFO_LEVEL),
    .RD_START(RD_START), .RD_ADRS(RD_ADRS), .RD_LEN(RD_LEN), .RD_READY(RD_READY),
    .RD_INT(RD_INT), .RD_STATUS(RD_STATUS), .RD_FIFO_WE(RD_FIFO_WE),
    .RD_FIFO_DATA(RD_FIFO_DATA), .RD_FIFO_FREE(RD_FIFO_FREE)
  );

  int n_cmp = 0;
  int n_fail = 0;
  logic clr;

  // Slave model: AW/AR always ready, W stalls one cycle in four, B after WLAST, R streams.
  logic [7:0]  cyc;
  logic [1:0]  bresp_tbl [4];
  int          b_idx, r_left, r_total;
  always @(posedge ACLK) cyc <= cyc + 8'd1;
  assign axi.AWREADY = 1'b1;
  assign axi.ARREADY = 1'b1;
  assign axi.WREADY  = (cyc[1:0] != 2'd3);
  assign axi.RVALID  = (r_left != 0);
  assign axi.RLAST   = (r_left == 1);
  assign axi.RRESP   = 2'b00;
  assign axi.RDATA   = 64'(r_total);

  always @(posedge ACLK) begin
    if (!ARESETN || clr) begin
      axi.BVALID <= 1'b0;
      axi.BRESP  <= 2'b00;
      b_idx      <= 0;
    end else if (axi.BVALID && axi.BREADY) begin
      axi.BVALID <= 1'b0;
      b_idx      <= b_idx + 1;
    end else if (axi.WVALID && axi.WREADY && axi.WLAST) begin
      axi.BVALID <= 1'b1;
      axi.BRESP  <= bresp_tbl[b_idx % 4];
    end
  end

  always @(posedge ACLK) begin
    if (!ARESETN || clr) begin
      r_left  <= 0;
      r_total <= 0;
    end else if (axi.ARVALID && axi.ARREADY) begin
      r_left <= int'(axi.ARLEN) + 1;
    end else if (axi.RVALID && axi.RREADY) begin
      r_left  <= r_left - 1;
      r_total <= r_total + 1;
    end
  end

  // Monitors
  logic [31:0] aw_addr [8], ar_addr [8];
  logic [7:0]  aw_len [8], ar_len [8];
  int          aw_n, ar_n, re_cnt, we_cnt, wint_cnt, rint_cnt, awv_cyc, wbad;
  logic [63:0] rd_sum;
  logic        int_on_last;
  logic [1:0]  wst_at_int;
  always @(posedge ACLK) begin
    if (clr) begin
      aw_n <= 0; ar_n <= 0; re_cnt <= 0; we_cnt <= 0; wint_cnt <= 0; rint_cnt <= 0;
      awv_cyc <= 0; wbad <= 0; rd_sum <= '0; int_on_last <= 1'b0; wst_at_int <= 2'b00;
    end else begin
      if (axi.AWVALID) awv_cyc <= awv_cyc + 1;
      if (axi.AWVALID && axi.AWREADY) begin
        aw_addr[aw_n % 8] <= axi.AWADDR;
        aw_len[aw_n % 8]  <= axi.AWLEN;
        aw_n              <= aw_n + 1;
      end
      if (axi.ARVALID && axi.ARREADY) begin
        ar_addr[ar_n % 8] <= axi.ARADDR;
        ar_len[ar_n % 8]  <= axi.ARLEN;
        ar_n              <= ar_n + 1;
      end
      if (axi.WVALID && (axi.WSTRB != 8'hFF || axi.WDATA !== WR_FIFO_DATA)) wbad <= wbad + 1;
      if (WR_FIFO_RE) re_cnt <= re_cnt + 1;
      if (RD_FIFO_WE) begin
        we_cnt <= we_cnt + 1;
        rd_sum <= rd_sum + RD_FIFO_DATA;
      end
      if (WR_INT) begin
        wint_cnt   <= wint_cnt + 1;
        wst_at_int <= WR_STATUS;
      end
      if (RD_INT) begin
        rint_cnt <= rint_cnt + 1;
        if (axi.RVALID && axi.RLAST) int_on_last <= 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge ACLK);
    clr = 1'b0;
  endtask

  task automatic start_wr(input logic [31:0] adr, input logic [31:0] len);
    WR_ADRS = adr; WR_LEN = len; WR_START = 1'b1;
    @(negedge ACLK);
    WR_START = 1'b0;
  endtask

  task automatic start_rd(input logic [31:0] adr, input logic [31:0] len);
    RD_ADRS = adr; RD_LEN = len; RD_START = 1'b1;
    @(negedge ACLK);
    RD_START = 1'b0;
  endtask

  task automatic wait_wint(input int budget);
    for (int g = 0; g < budget && wint_cnt == 0; g++) @(negedge ACLK);
    repeat (3) @(negedge ACLK);
  endtask

  task automatic wait_rint(input int budget);
    for (int g = 0; g < budget && rint_cnt == 0; g++) @(negedge ACLK);
    repeat (3) @(negedge ACLK);
  endtask

  initial begin
    ARESETN = 1'b0; clr = 1'b1; MASTER_RST = 1'b0;
    WR_START = 1'b0; WR_ADRS = '0; WR_LEN = '0; RD_START = 1'b0; RD_ADRS = '0; RD_LEN = '0;
    WR_FIFO_DATA = 64'hDEAD_BEEF_0123_4567; WR_FIFO_LEVEL = 10'd256; RD_FIFO_FREE = 10'd512;
    for (int i = 0; i < 4; i++) bresp_tbl[i] = 2'b00;
    repeat (3) @(negedge ACLK);

    // Reset state
    check("rst ready", {WR_READY, RD_READY}, 2'b11);
    check("rst ctrl", {axi.AWVALID, axi.WVALID, axi.BREADY, axi.ARVALID, axi.RREADY,
                       WR_FIFO_RE, RD_FIFO_WE, WR_INT, RD_INT}, 9'd0);
    check("rst status", {WR_STATUS, RD_STATUS}, 4'd0);
    check("rst ax", {axi.AWADDR, axi.AWLEN, axi.ARADDR, axi.ARLEN}, 80'd0);
    check("size/burst", {axi.AWSIZE, axi.AWBURST, axi.ARSIZE, axi.ARBURST}, 10'b011_01_011_01);
    check("sidebands", {axi.AWID, axi.AWLOCK, axi.AWCACHE, axi.AWPROT, axi.AWQOS, axi.AWUSER,
                        axi.ARID, axi.ARLOCK, axi.ARCACHE, axi.ARPROT, axi.ARQOS, axi.ARUSER},
          {14'b0_0_0011_000_0000_1, 14'b0_0_0011_000_0000_1});
    ARESETN = 1'b1;
    @(negedge ACLK);
    clr = 1'b0;

    // 4KB write at 0x1000: two 256-beat bursts
    do_clr();
    start_wr(32'h1000, 32'd4096);
    check("A busy", WR_READY, 1'b0);
    wait_wint(3000);
    check("A int", wint_cnt, 1);
    check("A aw n", aw_n, 2);
    check("A aw0", {aw_addr[0], aw_len[0]}, {32'h1000, 8'd255});
    check("A aw1", {aw_addr[1], aw_len[1]}, {32'h1800, 8'd255});
    check("A re", re_cnt, 512);
    check("A status", WR_STATUS, 2'b00);
    check("A ready", WR_READY, 1'b1);
    check("A wbus", wbad, 0);

    // Read across 4KB boundary: 8 beats then 24 beats
    do_clr();
    start_rd(32'h0FC0, 32'd256);
    wait_rint(500);
    check("B int", rint_cnt, 1);
    check("B int on rlast", int_on_last, 1'b1);
    check("B ar n", ar_n, 2);
    check("B ar0", {ar_addr[0], ar_len[0]}, {32'h0FC0, 8'd7});
    check("B ar1", {ar_addr[1], ar_len[1]}, {32'h1000, 8'd23});
    check("B we", we_cnt, 32);
    check("B data sum", rd_sum, 64'd496);
    check("B ready", RD_READY, 1'b1);

    // FIFO level gating: 16-beat burst waits for level 16
    do_clr();
    WR_FIFO_LEVEL = 10'd10;
    start_wr(32'h2000, 32'd128);
    repeat (20) @(negedge ACLK);
    check("C gated awvalid", awv_cyc, 0);
    check("C gated busy", WR_READY, 1'b0);
    WR_FIFO_LEVEL = 10'd16;
    wait_wint(500);
    check("C aw", {aw_n, aw_addr[0], aw_len[0]}, {32'd1, 32'h2000, 8'd15});
    check("C re", re_cnt, 16);
    WR_FIFO_LEVEL = 10'd256;

    // SLVERR on the middle burst of three is sticky
    do_clr();
    bresp_tbl[1] = 2'b10;
    start_wr(32'h4000, 32'd6144);
    wait_wint(4000);
    check("D int", wint_cnt, 1);
    check("D status at int", wst_at_int, 2'b10);
    check("D status held", WR_STATUS, 2'b10);
    check("D aw n", aw_n, 3);
    check("D aw2", aw_addr[2], 32'h5000);
    check("D re", re_cnt, 768);
    bresp_tbl[1] = 2'b00;

    // Abort during read beat 5 of 256
    do_clr();
    start_rd(32'h8000, 32'd2048);
    for (int g = 0; g < 200 && r_total != 4; g++) @(negedge ACLK);
    MASTER_RST = 1'b1;
    @(negedge ACLK);
    MASTER_RST = 1'b0;
    for (int g = 0; g < 600 && !RD_READY; g++) @(negedge ACLK);
    repeat (10) @(negedge ACLK);
    check("E beats", r_total, 256);
    check("E we", we_cnt, 5);
    check("E no int", rint_cnt, 0);
    check("E ar n", ar_n, 1);
    check("E ready", RD_READY, 1'b1);

    // Zero-length write
    do_clr();
    start_wr(32'h3000, 32'd0);
    check("F int", WR_INT, 1'b1);
    check("F ready", WR_READY, 1'b1);
    repeat (5) @(negedge ACLK);
    check("F no aw", {aw_n, awv_cyc}, 64'd0);
    check("F int once", wint_cnt, 1);

    // START together with MASTER_RST in idle: abort wins
    do_clr();
    MASTER_RST = 1'b1;
    start_wr(32'h6000, 32'd64);
    MASTER_RST = 1'b0;
    check("G ready", WR_READY, 1'b1);
    repeat (10) @(negedge ACLK);
    check("G no traffic", {aw_n, wint_cnt}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/aq_axi_sdma_master_p.md
Name: aq_axi_sdma_master_p

Overview:
Parametrised single-outstanding-burst AXI4 DMA master with independent write (FIFO→memory) and read (memory→FIFO) channels. Generalises the 64-bit fixed-2KB engine: configurable data width and maximum burst length, byte-granular lengths, 4KB-boundary burst splitting, FIFO-level-gated issue, sticky response status and a burst-safe abort. It sits between the register/control block and the AXI interconnect, in the same place as the current sdma64 master.

Parameters:
DATA_W, 64, AXI data width in bits (64/128/256); BYTES = DATA_W/8, SH = log2(BYTES).
MAX_BURST, 256, maximum beats per burst; power of two, 1..256.
LVL_W, 10, width of the FIFO level/free inputs.

Ports:
ACLK  in  1  clock.
ARESETN  in  1  asynchronous active-low reset.
M_AXI_AWADDR/AWLEN/AWSIZE/AWBURST/AWVALID  out  32/8/3/2/1  write-address channel; M_AXI_AWREADY in 1.
M_AXI_WDATA/WSTRB/WLAST/WVALID  out  DATA_W/BYTES/1/1  write-data channel; M_AXI_WREADY in 1.
M_AXI_BRESP/BVALID  in  2/1  write response; M_AXI_BREADY out 1.
M_AXI_ARADDR/ARLEN/ARSIZE/ARBURST/ARVALID  out  32/8/3/2/1  read-address channel; M_AXI_ARREADY in 1.
M_AXI_RDATA/RRESP/RLAST/RVALID  in  DATA_W/2/1/1  read data; M_AXI_RREADY out 1.
Constant AXI sidebands (ID=0, LOCK=0, CACHE=4'b0011, PROT=0, QOS=0, USER=1)  out.
MASTER_RST  in  1  abort both channels.
WR_START, WR_ADRS, WR_LEN  in  1/32/32  write job; address BYTES-aligned, length in bytes and a multiple of BYTES.
WR_READY, WR_INT, WR_STATUS  out  1/1/2  idle flag, one-cycle done pulse, sticky OR of BRESP.
WR_FIFO_RE, WR_FIFO_DATA, WR_FIFO_LEVEL  out/in/in  1/DATA_W/LVL_W  first-word-fall-through source FIFO.
RD_START, RD_ADRS, RD_LEN  in  1/32/32  read job (same alignment rules as the write job).
RD_READY, RD_INT, RD_STATUS  out  1/1/2  idle flag, done pulse, sticky OR of RRESP.
RD_FIFO_WE, RD_FIFO_DATA, RD_FIFO_FREE  out/out/in  1/DATA_W/LVL_W  sink FIFO.

Behaviour:
- Reset: all VALIDs, BREADY/RREADY, RE/WE and INT = 0; READY = 1; STATUS = 0; AxLEN and AxADDR = 0; AxSIZE = SH and AxBURST = 2'b01 at all times.
- Write FSM: IDLE→CALC→GATE→AW→W→B→(CALC | IDLE).
  - IDLE: WR_START latches address; remaining bytes = WR_LEN; STATUS is cleared. Any START while READY=0 is ignored.
  - LEN=0: INT pulses the cycle after START; no AXI traffic.
  - CALC: beats = min(MAX_BURST, rem>>SH, (4096−adr[11:0])>>SH), registered. AWLEN = beats−1.
  - GATE: advance once WR_FIFO_LEVEL ≥ beats.
  - AW: AWVALID = 1 until AWREADY. The AW handshake is the only exit.
  - W: WVALID stays 1 for the whole state. WSTRB is all ones. WLAST is asserted on beat `beats`. WR_FIFO_RE = WVALID & WREADY.
  - B: BREADY = 1; on BVALID, STATUS |= BRESP, adr += beats<<SH, rem −= beats<<SH. If rem = 0, WR_INT pulses 1 cycle and the FSM goes to IDLE; otherwise it returns to CALC.
- Read FSM: IDLE→CALC→GATE→AR→R→(CALC | IDLE).
  - Burst computation is identical to the write FSM; GATE waits until RD_FIFO_FREE ≥ beats.
  - AR: ARVALID held until ARREADY.
  - R: RREADY = 1 (space is already reserved). RD_FIFO_WE = RVALID & RREADY. RD_FIFO_DATA = RDATA.
  - Every accepted beat ORs RRESP into STATUS.
  - RVALID & RLAST ends the burst. RD_INT pulses on the final beat of the job. RLAST is trusted over the internal count.
- Address/length arithmetic is 32-bit. A burst never crosses a 4KB boundary. Address wrap at 2^32 is not checked (software guarantees no wrap).
- MASTER_RST: latched as abort-pending per channel.
  - In IDLE/CALC/GATE: return to IDLE the next cycle.
  - In AW/W/B (AR/R): finish the current AXI burst legally.
    - W beats still read the FIFO.
    - R beats are accepted, but RD_FIFO_WE is forced 0.
  - Then go to IDLE with no INT. STATUS retains its value.
  - Abort-pending clears on entering IDLE.
- Simultaneous START and MASTER_RST in IDLE: abort wins and the job is not started.
- The two channels are fully independent and may run concurrently.

Test Plan:
- DATA_W=64, WR_ADRS=0x1000, LEN=4096, LEVEL=256 → AW at 0x1000 and 0x1800, both AWLEN=255; 512 WR_FIFO_RE; one WR_INT; STATUS=0.
- RD_ADRS=0x0FC0, LEN=256 → AR 0x0FC0/ARLEN=7, then AR 0x1000/ARLEN=23; 32 RD_FIFO_WE; RD_INT on the last RLAST.
- MAX_BURST=16, WR_LEN=128, LEVEL held at 10 for 20 cycles then 16 → AWVALID stays 0 until LEVEL=16; AWLEN=15.
- BRESP=2'b10 on the 2nd of 3 write bursts → WR_STATUS=2'b10 at WR_INT; the 3rd burst is still issued.
- MASTER_RST asserted on R beat 5 of 256 → remaining 251 beats accepted with RD_FIFO_WE=0; RD_READY=1 after RLAST; no RD_INT; no new AR.
- WR_START with LEN=0 → WR_INT one cycle later; AWVALID never 1; WR_READY returns to 1.
